// File: rtl/polygon_area_pkg.sv
// Shared constants and state encoding for the shoelace polygon-area block.
package polygon_pkg;

    localparam int unsigned DEF_N     = 6;
    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_ACC_W = 2 * DEF_W + 4;
    localparam int unsigned DEF_RES_W = 2 * DEF_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CLOSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/polygon_area_cross_term.sv
// Signed 2-D cross product xa*yb - xb*ya of two unsigned vertices.
module cross_term #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]          xa,
    input  logic [W-1:0]          ya,
    input  logic [W-1:0]          xb,
    input  logic [W-1:0]          yb,
    output logic signed [2*W:0]   term
);

    localparam int unsigned PROD_W = 2 * W;

    logic [PROD_W-1:0] prod_a;
    logic [PROD_W-1:0] prod_b;

    assign prod_a = PROD_W'(xa) * PROD_W'(yb);
    assign prod_b = PROD_W'(xb) * PROD_W'(ya);

    // Each product is below 2^(2W), so the difference always fits 2W+1 signed bits.
    assign term = $signed({1'b0, prod_a}) - $signed({1'b0, prod_b});

endmodule

// File: rtl/polygon_area.sv
// Shoelace-formula area and orientation of an N-vertex frame, one result pulse per frame.
module polygon_area
    import polygon_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned ACC_W = 2 * W + 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [W-1:0]       inX,
    input  logic [W-1:0]       inY,
    output logic               busy,
    output logic [2*W+1:0]     area,
    output logic               area_half,
    output logic               cw,
    output logic               out_valid
);

    localparam int unsigned RES_W  = 2 * W + 2;
    localparam int unsigned TERM_W = 2 * W + 1;
    localparam int unsigned CNT_W  = $clog2(N + 1);

    state_t                    state, state_next;
    logic signed [ACC_W-1:0]   acc, acc_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic [W-1:0]              first_x, first_y, first_x_next, first_y_next;
    logic [W-1:0]              prev_x, prev_y, prev_x_next, prev_y_next;
    logic [RES_W-1:0]          area_next;
    logic                      area_half_next;
    logic                      cw_next;
    logic                      out_valid_next;
    logic                      busy_next;

    logic [W-1:0]              op_x;
    logic [W-1:0]              op_y;
    logic signed [TERM_W-1:0]  term;
    logic [ACC_W-1:0]          mag;

    // Operand B is the incoming vertex while accumulating, the first vertex when closing.
    assign op_x = (state == CLOSE) ? first_x : inX;
    assign op_y = (state == CLOSE) ? first_y : inY;

    cross_term #(
        .W (W)
    ) u_cross_term (
        .xa   (prev_x),
        .ya   (prev_y),
        .xb   (op_x),
        .yb   (op_y),
        .term (term)
    );

    // State and datapath register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            first_x   <= '0;
            first_y   <= '0;
            prev_x    <= '0;
            prev_y    <= '0;
            area      <= '0;
            area_half <= 1'b0;
            cw        <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            first_x   <= first_x_next;
            first_y   <= first_y_next;
            prev_x    <= prev_x_next;
            prev_y    <= prev_y_next;
            area      <= area_next;
            area_half <= area_half_next;
            cw        <= cw_next;
            out_valid <= out_valid_next;
            busy      <= busy_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        cnt_next       = cnt;
        first_x_next   = first_x;
        first_y_next   = first_y;
        prev_x_next    = prev_x;
        prev_y_next    = prev_y;
        area_next      = area;
        area_half_next = area_half;
        cw_next        = cw;
        out_valid_next = 1'b0;
        mag            = acc[ACC_W-1] ? $unsigned(-acc) : $unsigned(acc);

        case (state)
            IDLE: begin
                if (in_valid) begin
                    first_x_next = inX;
                    first_y_next = inY;
                    prev_x_next  = inX;
                    prev_y_next  = inY;
                    acc_next     = '0;
                    cnt_next     = CNT_W'(1);
                    state_next   = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_next    = acc + ACC_W'(term);
                    prev_x_next = inX;
                    prev_y_next = inY;
                    cnt_next    = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N - 1)) begin
                        state_next = CLOSE;
                    end
                end
            end
            CLOSE: begin
                acc_next   = acc + ACC_W'(term);
                state_next = DONE;
            end
            DONE: begin
                cw_next        = acc[ACC_W-1];
                area_next      = RES_W'(mag >> 1);
                area_half_next = mag[0];
                out_valid_next = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == CLOSE) || (state_next == DONE);
    end

endmodule

// File: tb/tb_polygon_area.sv
// Scoreboard bench for polygon_area: directed test-plan frames plus randomized frames.
module tb_polygon_area;
    import polygon_pkg::*;

    localparam int unsigned N     = DEF_N;
    localparam int unsigned W     = DEF_W;
    localparam int unsigned RES_W = 2 * W + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [W-1:0]     inX;
    logic [W-1:0]     inY;
    logic             busy;
    logic [RES_W-1:0] area;
    logic             area_half;
    logic             cw;
    logic             out_valid;

    polygon_area #(
        .N     (N),
        .W     (W),
        .ACC_W (2 * W + 4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .inX       (inX),
        .inY       (inY),
        .busy      (busy),
        .area      (area),
        .area_half (area_half),
        .cw        (cw),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint area;
        int     half;
        int     cw;
        int     cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vx[N];
    int   vy[N];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: signed shoelace sum over the closed vertex loop.
    task automatic model(output exp_t e);
        longint s = 0;
        longint m;
        for (int i = 0; i < int'(N); i++) begin
            int j = (i + 1) % int'(N);
            s += longint'(vx[i]) * longint'(vy[j]) - longint'(vx[j]) * longint'(vy[i]);
        end
        m      = (s < 0) ? -s : s;
        e.area = m / 2;
        e.half = int'(m % 2);
        e.cw   = (s < 0) ? 1 : 0;
        e.cyc  = 0;
    endtask

    task automatic set_pts(input int p[2*N]);
        for (int i = 0; i < int'(N); i++) begin
            vx[i] = p[2*i];
            vy[i] = p[2*i+1];
        end
    endtask

    task automatic reverse_pts();
        int tx[N];
        int ty[N];
        for (int i = 0; i < int'(N); i++) begin
            tx[i] = vx[N-1-i];
            ty[i] = vy[N-1-i];
        end
        vx = tx;
        vy = ty;
    endtask

    // Drives one frame, then two cycles of gap (optionally with junk vertices while busy).
    task automatic send_frame(input int bmin, input int bmax, input bit inject);
        exp_t e;
        model(e);
        for (int i = 0; i < int'(N); i++) begin
            if (i > 0) begin
                int nb = int'($urandom_range(bmax, bmin));
                repeat (nb) begin
                    in_valid = 1'b0;
                    inX      = W'($urandom_range(255, 0));
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            inX      = W'(vx[i]);
            inY      = W'(vy[i]);
            @(posedge clk);
            #1;
        end
        e.cyc = cyc;
        sb.push_back(e);
        check("busy_close", longint'(busy), 1);
        in_valid = inject;
        inX      = W'(200);
        inY      = W'(200);
        @(posedge clk);
        #1;
        check("busy_done", longint'(busy), 1);
        @(posedge clk);
        #1;
        check("busy_idle", longint'(busy), 0);
        in_valid = 1'b0;
    endtask

    // Monitor: every out_valid pulse must match the oldest expected frame result.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got pulse expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("area", longint'(area), e.area);
                check("area_half", longint'(area_half), longint'(e.half));
                check("cw", longint'(cw), longint'(e.cw));
                check("latency", longint'(cyc), longint'(e.cyc + 2));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int hex1[2*N]  = '{0,0, 10,0, 10,10, 5,15, 0,10, 0,5};
    int fulls[2*N] = '{0,0, 128,0, 255,0, 255,255, 128,255, 0,255};
    int oddp[2*N]  = '{0,0, 1,0, 0,1, 0,1, 0,1, 0,0};

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        inX      = '0;
        inY      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_area", longint'(area), 0);
        check("rst_half", longint'(area_half), 0);
        check("rst_cw", longint'(cw), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        set_pts(hex1);
        send_frame(0, 0, 1'b0);
        reverse_pts();
        send_frame(0, 0, 1'b0);
        set_pts(fulls);
        send_frame(0, 0, 1'b0);
        set_pts(oddp);
        send_frame(0, 0, 1'b0);

        // Partial frame aborted by reset.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            inX      = W'(50 + i);
            inY      = W'(60 + i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_area", longint'(area), 0);
        check("midrst_busy", longint'(busy), 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_pulse", longint'(out_valid), 0);

        set_pts(hex1);
        send_frame(1, 1, 1'b0);
        send_frame(0, 0, 1'b1);
        send_frame(0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("hold_area", longint'(area), 125);
        check("hold_cw", longint'(cw), 0);

        for (int f = 0; f < 40; f++) begin
            int lim = (f % 4 == 0) ? 3 : 255;
            for (int i = 0; i < int'(N); i++) begin
                vx[i] = int'($urandom_range(lim, 0));
                vy[i] = int'($urandom_range(lim, 0));
            end
            send_frame(0, 2, 1'($urandom_range(1, 0)));
            if ($urandom_range(3, 0) == 0) begin
                repeat (int'($urandom_range(3, 1))) @(posedge clk);
                #1;
            end
        end

        repeat (6) @(posedge clk);
        #1;
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("missing_out_valid", 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/polygon_area.md
# polygon_area

- Downstream stage of the point-ordering block.
- Consumes the ordered vertex stream it emits: one (X,Y) pair per valid cycle, N vertices per frame.
- Computes the enclosed polygon area with the shoelace formula, plus orientation (CW/CCW).
- Emits one result per frame with a single-cycle valid pulse.

## Interface
- `N`, 6: vertices per frame (3..8)
- `W`, 8: coordinate width (unsigned)
- `ACC_W`, 2*W+4: signed accumulator width
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high
- `in_valid` in 1: vertex present this cycle
- `inX` in W: vertex X, unsigned
- `inY` in W: vertex Y, unsigned
- `busy` out 1: high in CLOSE and DONE; `in_valid` ignored while high
- `area` out 2*W+2: floor(|S|/2), S = signed shoelace sum
- `area_half` out 1: |S| bit 0 (true area = area + 0.5)
- `cw` out 1: 1 when S < 0 (clockwise order)
- `out_valid` out 1: one-cycle pulse, result fields valid

## Operation
- States: IDLE, ACCUM, CLOSE, DONE.
- **IDLE**
  - `in_valid`: first←(inX,inY), prev←(inX,inY), acc←0, cnt←1, go ACCUM.
- **ACCUM**
  - `in_valid`: acc += prev.x·in.y − in.x·prev.y, prev←in, cnt++.
  - When the accepted vertex is the N-th (cnt was N−1), go CLOSE.
  - `in_valid` low: hold state (bubbles of any length allowed).
- **CLOSE**
  - acc += prev.x·first.y − first.x·prev.y, go DONE. `in_valid` ignored.
- **DONE**
  - Register the result fields, pulse `out_valid`, go IDLE. `in_valid` ignored.
  - Result fields: `cw`←acc sign, `area`←|acc|>>1, `area_half`←|acc|[0].
- **Arithmetic**
  - Operands zero-extended to W+1 signed before multiply.
  - Products are 2W bits unsigned.
  - Cross term is 2W+1 bits signed.
  - `acc` is ACC_W signed, cannot overflow for N≤8.
  - |acc| is at most 2W+3 bits; `area` fits 2W+2.
- **Degenerate input**
  - Repeated or collinear vertices accepted; zero area is legal (cw=0).
- **Reset values**
  - `area`, `area_half`, `cw`, `out_valid`, `busy` = 0.
  - State IDLE; cnt, acc, first, prev = 0.
- **Reset mid-frame**
  - Partial frame discarded, no `out_valid`.
  - First `in_valid` after deassertion starts a new frame.
- **Result holding**
  - `area`, `area_half`, `cw` hold their last values until the next DONE.

## Timing
- N-th vertex sampled at edge k → CLOSE after k, DONE after k+1.
- Result fields and `out_valid` registered at edge k+2 and visible in the following cycle.
- `out_valid` is high for exactly one cycle.
- `busy` is high in the two cycles after edge k (CLOSE, DONE).
- Earliest next-frame first vertex is sampled at edge k+3.
- A vertex presented while `busy` is dropped with no error flag; the upstream must gap ≥2 cycles between frames.

## Structure
- Package `polygon_pkg`: N, W, ACC_W defaults; state enum {IDLE, ACCUM, CLOSE, DONE}; result width constant 2W+2.
- Sub-module `cross_term`: combinational, ports xa, ya, xb, yb (W) → xa·yb − xb·ya (2W+1 signed).
  - Instantiated once.
  - Operand B muxed: current input in ACCUM, first vertex in CLOSE.

## Test plan
- **CCW hexagon:** (0,0),(10,0),(10,10),(5,15),(0,10),(0,5) on consecutive cycles → S=250; area=125, area_half=0, cw=0; out_valid 2 cycles after last vertex.
- **Reversed order:** same six points reversed → area=125, area_half=0, cw=1.
- **Full-scale:** (0,0),(128,0),(255,0),(255,255),(128,255),(0,255) → S=130050; area=65025, area_half=0, cw=0.
- **Odd sum:** (0,0),(1,0),(0,1),(0,1),(0,1),(0,0) → S=1; area=0, area_half=1, cw=0.
- **Reset mid-frame, then bubbles:** 3 vertices, reset pulse (no out_valid), then hexagon 1 with 1-cycle bubbles between vertices → area=125, out_valid 2 cycles after 6th vertex.
- **Input while busy:** extra `in_valid` with (200,200) during CLOSE and DONE → ignored; frame result unchanged (125).
  - Then hexagon 1 starting 3 cycles after the last vertex → second out_valid, area=125.
